// File: rtl/delay_digit_scan.sv
// Purpose: 4-digit BCD delay setting adjusted by inc/dec pulses, scanned one digit at a time onto a shared 7-seg decoder.
// Latency: delay_bcd updates 1 cycle after a pulse; d/an follow 1 cycle later (all outputs registered).
// Backpressure: none; every inc/dec pulse is accepted, saturating at MIN_BCD/MAX_BCD.
module delay_digit_scan #(
  parameter int          SCAN_DIV = 100_000,
  parameter logic [15:0] INIT_BCD = 16'h0100,
  parameter logic [15:0] MIN_BCD  = 16'h0001,
  parameter logic [15:0] MAX_BCD  = 16'h9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        dec,
  output logic [15:0] delay_bcd,
  output logic [3:0]  d,
  output logic [3:0]  an
);

  localparam int            TW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);

  logic [TW-1:0] tick;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic          tick_wrap;
  logic [15:0]   bcd_up;
  logic [15:0]   bcd_dn;
  logic [15:0]   delay_nxt;

  // BCD +1 and -1 with ripple carry/borrow through all four digits
  always_comb begin
    logic carry;
    logic borrow;
    bcd_up = delay_bcd;
    bcd_dn = delay_bcd;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (delay_bcd[4*i +: 4] == 4'd9) begin
          bcd_up[4*i +: 4] = 4'd0;
        end else begin
          bcd_up[4*i +: 4] = delay_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (delay_bcd[4*i +: 4] == 4'd0) begin
          bcd_dn[4*i +: 4] = 4'd9;
        end else begin
          bcd_dn[4*i +: 4] = delay_bcd[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Next delay value: only a lone pulse moves it, and never past the limits
  always_comb begin
    delay_nxt = delay_bcd;
    if (inc && !dec && (delay_bcd != MAX_BCD)) begin
      delay_nxt = bcd_up;
    end else if (dec && !inc && (delay_bcd != MIN_BCD)) begin
      delay_nxt = bcd_dn;
    end
  end

  // Scan index advances on the tick counter wrap; d/an are driven from the next index
  // so they stay aligned with each other
  always_comb begin
    tick_wrap = (tick == TICK_LAST);
    idx_nxt   = tick_wrap ? idx + 2'd1 : idx;
  end

  // State and registered outputs; d samples the current delay every cycle so a
  // mid-slot change shows up one cycle after delay_bcd
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_bcd <= INIT_BCD;
      tick      <= '0;
      idx       <= 2'd0;
      an        <= 4'b1110;
      d         <= INIT_BCD[3:0];
    end else begin
      delay_bcd <= delay_nxt;
      tick      <= tick_wrap ? '0 : tick + TW'(1);
      idx       <= idx_nxt;
      an        <= ~(4'b0001 << idx_nxt);
      d         <= delay_bcd[{idx_nxt, 2'b00} +: 4];
    end
  end

endmodule

// File: tb/tb_delay_digit_scan.sv
// Bench for delay_digit_scan with SCAN_DIV=4: scoreboarded delay updates plus a
// per-cycle scan monitor for an/d.
module tb_delay_digit_scan;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        inc   = 1'b0;
  logic        dec   = 1'b0;
  logic [15:0] delay_bcd;
  logic [3:0]  d;
  logic [3:0]  an;

  always #5 clk = ~clk;

  delay_digit_scan #(
    .SCAN_DIV(4),
    .INIT_BCD(16'h0100),
    .MIN_BCD (16'h0001),
    .MAX_BCD (16'h9999)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc),
    .dec      (dec),
    .delay_bcd(delay_bcd),
    .d        (d),
    .an       (an)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int bcd2int(input logic [15:0] b);
    return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  logic [15:0] model_bcd = 16'h0100;
  logic [15:0] exp_q[$];
  logic [15:0] d_src = 16'h0100;
  int          edges = 0;
  bit          mon_en = 1'b0;

  // Edge count since reset sets the expected slot; d_src is the value d must show from
  always @(posedge clk) begin
    if (reset) begin
      edges <= 0;
      d_src <= 16'h0100;
    end else begin
      edges <= edges + 1;
      d_src <= model_bcd;
    end
  end

  // Scan monitor, sampled away from the active edge
  always @(negedge clk) begin
    int         ix;
    logic [3:0] ae;
    if (mon_en) begin
      ix = (edges / 4) % 4;
      ae = ~(4'b0001 << ix);
      chk("an_scan", {12'd0, an}, {12'd0, ae});
      chk("d_scan", {12'd0, d}, {12'd0, d_src[ix*4 +: 4]});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic i, input logic dd);
    int v;
    v = bcd2int(model_bcd);
    if (i && !dd && v < 9999) v++;
    else if (dd && !i && v > 1) v--;
    inc = i;
    dec = dd;
    exp_q.push_back(int2bcd(v));
    @(posedge clk);
    #1;
    inc = 1'b0;
    dec = 1'b0;
    model_bcd = exp_q.pop_front();
    chk("delay", delay_bcd, model_bcd);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_bcd = 16'h0100;
    exp_q.delete();
    chk("rst_delay", delay_bcd, 16'h0100);
    chk("rst_an", {12'd0, an}, 16'h000e);
    chk("rst_d", {12'd0, d}, 16'h0000);
    mon_en = 1'b1;
  endtask

  task automatic go_to(input logic [15:0] target);
    for (int k = 0; k < 12000 && model_bcd != target; k++) begin
      if (model_bcd < target) pulse(1'b1, 1'b0);
      else pulse(1'b0, 1'b1);
    end
    chk("goto", delay_bcd, target);
  endtask

  task automatic wait_an(input logic [3:0] want, input logic eq, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if ((an == want) == eq) found = 1'b1;
      else idle(1);
    end
    chk(tag, {15'd0, found}, 16'd1);
  endtask

  initial begin
    idle(2);
    do_reset();
    idle(20);

    // borrow then carry across two digits
    pulse(1'b0, 1'b1);
    chk("borrow", delay_bcd, 16'h0099);
    pulse(1'b1, 1'b0);
    chk("carry", delay_bcd, 16'h0100);

    // mid-slot update while digit 0 is displayed
    go_to(16'h0109);
    wait_an(4'b1110, 1'b0, "align_leave");
    wait_an(4'b1110, 1'b1, "align_enter");
    pulse(1'b1, 1'b0);
    chk("mid_delay", delay_bcd, 16'h0110);
    chk("mid_d_old", {12'd0, d}, 16'h0009);
    idle(1);
    chk("mid_d_new", {12'd0, d}, 16'h0000);
    chk("mid_an", {12'd0, an}, 16'h000e);

    // simultaneous inc and dec holds the value
    go_to(16'h0250);
    pulse(1'b1, 1'b1);
    chk("both", delay_bcd, 16'h0250);
    idle(8);

    // reset in the middle of a frame
    go_to(16'h0420);
    wait_an(4'b1011, 1'b1, "wait_an1011");
    do_reset();
    idle(10);

    // low-end saturation
    go_to(16'h0001);
    repeat (3) pulse(1'b0, 1'b1);
    chk("sat_lo", delay_bcd, 16'h0001);

    // high-end saturation
    go_to(16'h9999);
    pulse(1'b1, 1'b0);
    chk("sat_hi", delay_bcd, 16'h9999);
    idle(6);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
